y_argmax: RTL
=============

# y_argmax

Output-layer argmax stage that consumes the banked result vector y written by the matrix-vector multiplier. Scans both y BRAM banks in parallel, compares IEEE-754 single-precision words with pure integer logic, and reports the index (and optionally the value) of the largest element to the PS. Sits directly downstream of the multiplier; the PS starts it after the multiplier signals done, and uses the same ps_control/pl_status handshake.

## Interface
- P, 2: number of y banks; only 2 supported.
- addr_y_size, 12: y BRAM byte-address width.
- length_M, 512: total y elements; ROWS = length_M/P words per bank.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- ps_control  in  32  bit 0 = start; other bits ignored.
- pl_status  out  32  bit 0 = done; other bits 0.
- state  out  32  {29'b0, fsm state code}.
- bram_addr_y1, bram_addr_y2  out  addr_y_size  shared byte address for both banks.
- bram_rddata_y1, bram_rddata_y2  in  32  bank read data, 1-cycle latency.
- bram_wrdata_y1, bram_wrdata_y2  out  32  tied 0.
- bram_we_y1, bram_we_y2  out  4  tied 0 (read only).
- max_index  out  32  global index of largest element.
- max_value  out  32  raw bits of largest element (see Configuration).

## Operation
- Element mapping: bank k (0 = y1, 1 = y2), row r at byte address 4r -> global index r*P + k.
- Ordering key: sign=1 -> key = ~bits; sign=0 -> key = bits | 32'h8000_0000; compare keys unsigned. Consequences: +0 > -0; positive NaN beats all; negative NaN loses to all.
- Ties: strict greater-than replaces; lowest global index wins. Within a row bank 0 wins ties over bank 1.
- Per row: pick row winner from the two banks, then compare against running best; update best key/index.
- FSM states: IDLE=0, RUN=1, DRAIN=2, DONE=3.
- IDLE: address 0. ps_control[0]=1 -> RUN, clear running best (first row always loads), row counter 0.
- RUN: issue address 4*row, increment row each cycle; data of previous row evaluated each cycle after the first. Issuing row ROWS-1 -> DRAIN.
- DRAIN: evaluate last row; -> DONE, latching max_index/max_value.
- DONE: pl_status[0]=1; stays while ps_control[0]=1; ps_control[0]=0 -> IDLE.
- max_index/max_value hold their last result through IDLE until the next DONE update.
- Start deasserted during RUN/DRAIN: ignored; scan completes, DONE entered, then leaves to IDLE next cycle.

## Timing
- Reset: state IDLE, bram_addr 0, pl_status 0, max_index 0, max_value 0, running best cleared.
- Reset mid-scan: abandons scan in the cycle reset is sampled; all outputs as above.
- Start sampled in cycle T (IDLE) -> RUN from T+1; row r address driven in cycle T+1+r; data valid T+2+r.
- DRAIN in cycle T+1+ROWS; pl_status[0] and results valid from cycle T+2+ROWS (latency ROWS+2 = 258 for defaults).
- bram_addr max = 4*(ROWS-1) = 1020; must fit addr_y_size, no wrap.
- pl_status deasserts the cycle after ps_control[0]=0 is sampled in DONE.

## Configuration
- Y_ARGMAX_VALUE_EN defined: max_value register and output implemented, holding raw bits of the winning element.
- Undefined: no value register; max_value tied to 32'h0; index behaviour unchanged.

## Test plan
- All words 0 except bank1 row 100 = 32'h4040_0000 (3.0) -> max_index 201, max_value 32'h4040_0000, pl_status at cycle T+258.
- All elements -1.0 (32'hBF80_0000) except index 0 = -0.5 -> max_index 0; then all equal 1.0 -> max_index 0 (tie rule).
- Bank0 row 7 = +0 (32'h0000_0000), all others -0 (32'h8000_0000) -> max_index 14; swap to bank1 row 7 = 32'h7FC0_0000 (NaN) -> max_index 15.
- Bank0 and bank1 row 50 both 2.0, everything else smaller -> max_index 100.
- Reset asserted at T+40 -> state 0, pl_status 0, max_index 0; restart completes normally with correct result.
- Hold ps_control[0]=1 after done -> pl_status stays 1; drop it -> IDLE next cycle, max_index retained; compile without Y_ARGMAX_VALUE_EN -> max_value 0 in every scenario.

Source files
------------

// File: rtl/y_argmax_if.sv
// -----------------------------------------------------------------------------
// y_argmax_if
// Bundles the PS handshake, status/result words and the two y-bank BRAM ports
// of the y_argmax stage.
//
// Parameters
//   ADDR_W          y BRAM byte-address width
//
// Signals
//   ps_control      PS -> PL   bit 0 = start
//   pl_status       PL -> PS   bit 0 = done
//   state           PL -> PS   {29'b0, fsm state code}
//   bram_addr_y*    PL -> BRAM shared byte address (same value on both banks)
//   bram_rddata_y*  BRAM -> PL read data, 1-cycle latency
//   bram_wrdata_y*  PL -> BRAM tied 0
//   bram_we_y*      PL -> BRAM tied 0
//   max_index       PL -> PS   global index of the largest element
//   max_value       PL -> PS   raw bits of the largest element (0 when disabled)
//
// Modports
//   slave   the argmax stage itself
//   master  the PS / BRAM side (testbench)
// -----------------------------------------------------------------------------
interface y_argmax_if #(
   parameter int ADDR_W = 12
);
   logic [31:0]       ps_control;
   logic [31:0]       pl_status;
   logic [31:0]       state;
   logic [ADDR_W-1:0] bram_addr_y1;
   logic [ADDR_W-1:0] bram_addr_y2;
   logic [31:0]       bram_rddata_y1;
   logic [31:0]       bram_rddata_y2;
   logic [31:0]       bram_wrdata_y1;
   logic [31:0]       bram_wrdata_y2;
   logic [3:0]        bram_we_y1;
   logic [3:0]        bram_we_y2;
   logic [31:0]       max_index;
   logic [31:0]       max_value;

   modport slave (
      input  ps_control,
      input  bram_rddata_y1,
      input  bram_rddata_y2,
      output pl_status,
      output state,
      output bram_addr_y1,
      output bram_addr_y2,
      output bram_wrdata_y1,
      output bram_wrdata_y2,
      output bram_we_y1,
      output bram_we_y2,
      output max_index,
      output max_value
   );

   modport master (
      output ps_control,
      output bram_rddata_y1,
      output bram_rddata_y2,
      input  pl_status,
      input  state,
      input  bram_addr_y1,
      input  bram_addr_y2,
      input  bram_wrdata_y1,
      input  bram_wrdata_y2,
      input  bram_we_y1,
      input  bram_we_y2,
      input  max_index,
      input  max_value
   );
endinterface

// File: rtl/y_argmax.sv
// -----------------------------------------------------------------------------
// y_argmax
// Output-layer argmax over the banked y vector produced by the matrix-vector
// multiplier. Both y banks are read in parallel, one row per cycle; IEEE-754
// single-precision words are ordered with an integer key so no FP hardware is
// needed. The index (and optionally the raw value) of the largest element is
// reported to the PS through the ps_control/pl_status handshake.
//
// Parameters
//   P            number of y banks (only 2 supported)
//   addr_y_size  y BRAM byte-address width
//   length_M     total y elements; ROWS = length_M/P words per bank
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous, active-high
//   bus          y_argmax_if.slave (handshake, status, BRAM ports, results)
//
// Build option
//   Y_ARGMAX_VALUE_EN  when defined, max_value carries the raw bits of the
//                      winning element; otherwise max_value is tied to 0.
// -----------------------------------------------------------------------------
module y_argmax #(
   parameter int P           = 2,
   parameter int addr_y_size = 12,
   parameter int length_M    = 512
) (
   input  logic       clk,
   input  logic       reset,
   y_argmax_if.slave  bus
);

   localparam int ROWS  = length_M / P;
   localparam int ROW_W = $clog2(ROWS);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Maps float bits to an unsigned key whose integer order matches the
   // required ordering: negatives are bit-inverted, positives get the top bit
   // set. This puts +0 above -0, +NaN above everything, -NaN below everything.
   function automatic logic [31:0] order_key(input logic [31:0] w);
      if (w[31]) begin
         order_key = ~w;
      end else begin
         order_key = w | 32'h8000_0000;
      end
   endfunction

   state_t                   state_r;
   state_t                   state_s;
   logic [ROW_W-1:0]         row_r;
   logic [ROW_W-1:0]         row_s;
   logic [addr_y_size-1:0]   addr_r;
   logic                     eval_vld_r;
   logic [ROW_W-1:0]         eval_row_r;
   logic                     best_vld_r;
   logic [31:0]              best_key_r;
   logic [ROW_W:0]           best_idx_r;
   logic [31:0]              max_index_r;
   logic                     done_r;
   logic                     start_s;

   logic [31:0]              key0_s;
   logic [31:0]              key1_s;
   logic [31:0]              row_key_s;
   logic                     row_bank_s;
   logic                     take_s;
   logic [31:0]              new_key_s;
   logic [ROW_W:0]           new_idx_s;
   logic                     unused_s;

   assign start_s  = bus.ps_control[0];
   assign unused_s = ^bus.ps_control[31:1];

   // Next-state and row-counter logic of the scan FSM.
   always_comb begin
      state_s = state_r;
      row_s   = row_r;
      case (state_r)
         IDLE: begin
            row_s = {ROW_W{1'b0}};
            if (start_s) begin
               state_s = RUN;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            // row_r is the row whose address is on the bus this cycle.
            if (row_r == LAST_ROW) begin
               state_s = DRAIN;
            end else begin
               row_s = row_r + ROW_W'(1);
            end
         end
         DRAIN: begin
            state_s = DONE;
         end
         DONE: begin
            if (start_s) begin
               state_s = DONE;
            end else begin
               state_s = IDLE;
            end
         end
         default: begin
            state_s = IDLE;
            row_s   = {ROW_W{1'b0}};
         end
      endcase
   end

   // Row winner and running-best candidate for the data returning this cycle.
   always_comb begin
      key0_s = order_key(bus.bram_rddata_y1);
      key1_s = order_key(bus.bram_rddata_y2);
      // Bank 1 only wins on strictly greater so bank 0 takes row ties.
      if (key1_s > key0_s) begin
         row_key_s  = key1_s;
         row_bank_s = 1'b1;
      end else begin
         row_key_s  = key0_s;
         row_bank_s = 1'b0;
      end
      // Rows arrive in ascending order, so strict compare keeps lowest index.
      take_s = eval_vld_r && (!best_vld_r || (row_key_s > best_key_r));
      if (take_s) begin
         new_key_s = row_key_s;
         new_idx_s = {eval_row_r, row_bank_s};
      end else begin
         new_key_s = best_key_r;
         new_idx_s = best_idx_r;
      end
   end

   // FSM state, row counter, BRAM address and the one-cycle data-valid pipe.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         row_r      <= {ROW_W{1'b0}};
         addr_r     <= {addr_y_size{1'b0}};
         eval_vld_r <= 1'b0;
         eval_row_r <= {ROW_W{1'b0}};
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         row_r      <= row_s;
         if (state_s == RUN) begin
            addr_r <= addr_y_size'({row_s, 2'b00});
         end else begin
            addr_r <= {addr_y_size{1'b0}};
         end
         // Data for the row issued in a RUN cycle arrives one cycle later.
         eval_vld_r <= (state_r == RUN);
         eval_row_r <= row_r;
         done_r     <= (state_s == DONE);
      end
   end

   // Running best, cleared on start so the first evaluated row always loads.
   always_ff @(posedge clk) begin
      if (reset) begin
         best_vld_r <= 1'b0;
         best_key_r <= 32'h0000_0000;
         best_idx_r <= {(ROW_W + 1){1'b0}};
      end else if ((state_r == IDLE) && start_s) begin
         best_vld_r <= 1'b0;
         best_key_r <= 32'h0000_0000;
         best_idx_r <= {(ROW_W + 1){1'b0}};
      end else if (take_s) begin
         best_vld_r <= 1'b1;
         best_key_r <= new_key_s;
         best_idx_r <= new_idx_s;
      end else begin
         best_vld_r <= best_vld_r;
      end
   end

   // Result index, latched as DRAIN folds in the last row; held otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         max_index_r <= 32'h0000_0000;
      end else if (state_r == DRAIN) begin
         max_index_r <= 32'(new_idx_s);
      end else begin
         max_index_r <= max_index_r;
      end
   end

`ifdef Y_ARGMAX_VALUE_EN
   logic [31:0] row_val_s;
   logic [31:0] best_val_r;
   logic [31:0] max_value_r;

   assign row_val_s = row_bank_s ? bus.bram_rddata_y2 : bus.bram_rddata_y1;

   // Raw bits of the running best and the latched result value.
   always_ff @(posedge clk) begin
      if (reset) begin
         best_val_r  <= 32'h0000_0000;
         max_value_r <= 32'h0000_0000;
      end else begin
         if (take_s) begin
            best_val_r <= row_val_s;
         end else begin
            best_val_r <= best_val_r;
         end
         if (state_r == DRAIN) begin
            max_value_r <= take_s ? row_val_s : best_val_r;
         end else begin
            max_value_r <= max_value_r;
         end
      end
   end

   assign bus.max_value = max_value_r;
`else
   assign bus.max_value = 32'h0000_0000;
`endif

   assign bus.pl_status      = {31'h0000_0000, done_r};
   assign bus.state          = {29'h0000_0000, 1'b0, state_r};
   assign bus.bram_addr_y1   = addr_r;
   assign bus.bram_addr_y2   = addr_r;
   assign bus.bram_wrdata_y1 = 32'h0000_0000;
   assign bus.bram_wrdata_y2 = 32'h0000_0000;
   assign bus.bram_we_y1     = 4'h0;
   assign bus.bram_we_y2     = 4'h0;
   assign bus.max_index      = max_index_r;

endmodule
